// File: rtl/e_mdu_ctrl_pkg.sv
// Shared definitions for the E-stage multiply/divide controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package e_mdu_ctrl_pkg;

  // MDU operation codes as decoded in E
  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } mdu_state_e;

  // Default busy latencies
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Busy counter width; latencies must fit in it
  localparam int CNT_W = 8;

  // Ops that interpret their operands as two's complement
  function automatic logic op_is_signed(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/e_mdu_ctrl_if.sv
// E-stage to MDU bundle: issue side plus Busy and architectural HI/LO back.
// Latency: n/a (wiring only).
// Backpressure: Busy tells the issuer to hold further MDU ops.
interface e_mdu_ctrl_if;
  import e_mdu_ctrl_pkg::*;

  logic        Req;
  logic        Start;
  mdu_op_e     MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  // Issuing pipeline side
  modport master (
    output Req, Start, MDUOp, A, B,
    input  Busy, HI, LO
  );

  // MDU controller side
  modport slave (
    input  Req, Start, MDUOp, A, B,
    output Busy, HI, LO
  );

endinterface

// File: rtl/e_mdu_ctrl_mdu_arith.sv
// Combinational mult/div datapath producing the {HI,LO} result pair.
// Latency: zero cycles; the controller models the architectural delay.
// Backpressure: none.
module e_mdu_ctrl_mdu_arith
  import e_mdu_ctrl_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  mdu_op_e     op,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res
);

  logic        sgn;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_div;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  assign sgn = op_is_signed(op);

  // Product: sign/zero extend to 64 bits; the low 64 bits of the product are exact either way
  always_comb begin
    a_ext = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    b_ext = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    prod  = a_ext * b_ext;
  end

  // Divide on magnitudes so one unsigned divider serves both flavours.
  // INT_MIN / -1 falls out naturally: |INT_MIN| is 0x8000_0000 as unsigned,
  // and negating it back gives 0x8000_0000 with remainder 0.
  always_comb begin
    a_neg = sgn & a[31];
    b_neg = sgn & b[31];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    b_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag = a_mag / b_div;
    r_mag = a_mag % b_div;
    quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem   = a_neg ? -r_mag : r_mag;
  end

  // Result select; divide by zero yields all-ones quotient and the dividend as remainder
  always_comb begin
    hi_res = 32'd0;
    lo_res = 32'd0;
    case (op)
      MDU_MULT, MDU_MULTU: begin
        hi_res = prod[63:32];
        lo_res = prod[31:0];
      end
      MDU_DIV, MDU_DIVU: begin
        if (b == 32'd0) begin
          hi_res = a;
          lo_res = 32'hFFFF_FFFF;
        end else begin
          hi_res = rem;
          lo_res = quot;
        end
      end
      default: begin
        hi_res = 32'd0;
        lo_res = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/e_mdu_ctrl.sv
// E-stage MDU sequencer: owns HI/LO, models fixed mult/div latency, handles mthi/mtlo.
// Latency: mthi/mtlo visible next edge; mult/div commit MULT_CYCLES/DIV_CYCLES edges after accept.
// Backpressure: Busy is high while an op is in flight; Start during Busy is dropped.
module e_mdu_ctrl
  import e_mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,  // must be >= 1
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF    // must be >= 1
) (
  input  logic         clk,
  input  logic         reset,
  e_mdu_ctrl_if.slave  mdu
);

  mdu_state_e       state;
  mdu_state_e       state_n;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_n;
  logic [31:0]      hi_pend;
  logic [31:0]      hi_pend_n;
  logic [31:0]      lo_pend;
  logic [31:0]      lo_pend_n;
  logic [31:0]      hi_q;
  logic [31:0]      hi_n;
  logic [31:0]      lo_q;
  logic [31:0]      lo_n;
  logic [31:0]      hi_res;
  logic [31:0]      lo_res;
  logic             accept;

  e_mdu_ctrl_mdu_arith u_arith (
    .a      (mdu.A),
    .b      (mdu.B),
    .op     (mdu.MDUOp),
    .hi_res (hi_res),
    .lo_res (lo_res)
  );

  // A flushed instruction (Req) or an op arriving while busy never starts
  assign accept = mdu.Start & ~mdu.Req & (state == IDLE);

  // Next-state, counter, pending results and HI/LO updates
  always_comb begin
    state_n   = state;
    count_n   = count;
    hi_pend_n = hi_pend;
    lo_pend_n = lo_pend;
    hi_n      = hi_q;
    lo_n      = lo_q;
    case (state)
      IDLE: begin
        if (accept) begin
          case (mdu.MDUOp)
            MDU_MTHI: hi_n = mdu.A;
            MDU_MTLO: lo_n = mdu.A;
            MDU_MULT, MDU_MULTU: begin
              hi_pend_n = hi_res;
              lo_pend_n = lo_res;
              state_n   = MUL;
              count_n   = CNT_W'(MULT_CYCLES);
            end
            MDU_DIV, MDU_DIVU: begin
              hi_pend_n = hi_res;
              lo_pend_n = lo_res;
              state_n   = DIV;
              count_n   = CNT_W'(DIV_CYCLES);
            end
            default: begin
              state_n = IDLE;
            end
          endcase
        end
      end
      MUL, DIV: begin
        // Results become architectural only on the final busy edge
        if (count == CNT_W'(1)) begin
          hi_n    = hi_pend;
          lo_n    = lo_pend;
          state_n = IDLE;
          count_n = '0;
        end else begin
          count_n = count - CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        count_n = '0;
      end
    endcase
  end

  // State and architectural registers; reset aborts any in-flight op
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      hi_pend <= 32'd0;
      lo_pend <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      hi_pend <= hi_pend_n;
      lo_pend <= lo_pend_n;
      hi_q    <= hi_n;
      lo_q    <= lo_n;
    end
  end

  assign mdu.Busy = (state != IDLE);
  assign mdu.HI   = hi_q;
  assign mdu.LO   = lo_q;

endmodule
